// File: rtl/serial_uart_bridge.sv
// Byte-wide processor serial handshake to 8N1 UART bridge, with a FIFO in each direction.
// TX drains its FIFO onto uart_txd; RX samples uart_rxd and queues completed bytes.
module serial_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_tx_data,
  input  logic       cpu_tx_wren,
  output logic       cpu_tx_ready,
  output logic [7:0] cpu_rx_data,
  output logic       cpu_rx_valid,
  input  logic       cpu_rx_rden,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       tx_overflow,
  output logic       rx_overflow,
  output logic       rx_frame_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned NW    = FIFO_AW + 1;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  // TX FIFO
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [NW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               tx_ready_q, tx_ready_d, tx_ovf_q, tx_ovf_d;
  logic               tx_full, tx_empty, tx_push, tx_pop;

  // TX FSM
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  // RX FIFO
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [NW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [7:0]         rx_head_q, rx_head_d;
  logic               rx_valid_q, rx_valid_d, rx_ovf_q, rx_ovf_d;
  logic               rx_full, rx_empty, rx_push, rx_pop, rx_got;

  // RX FSM and synchronizer
  logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_tmr_q, rx_tmr_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ferr_q, rx_ferr_d;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = cpu_tx_wren && !tx_full;
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = rx_got && !rx_full;
  assign rx_pop   = cpu_rx_rden && !rx_empty;

  always_comb begin
    tx_wp_d    = tx_wp_q + FIFO_AW'(tx_push);
    tx_rp_d    = tx_rp_q + FIFO_AW'(tx_pop);
    tx_cnt_d   = tx_cnt_q + NW'(tx_push) - NW'(tx_pop);
    tx_ready_d = (tx_cnt_d != FULL_CNT);
    tx_ovf_d   = tx_ovf_q | (cpu_tx_wren & tx_full);
  end

  // TX FSM; STOP chains straight into START when another byte is queued
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rp_q];
          tx_tmr_d   = BIT_LOAD;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = BIT_LOAD;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_tmr_d = tx_tmr_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tx_tmr_q == '0) begin
          tx_tmr_d   = BIT_LOAD;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_tmr_d = tx_tmr_q - CW'(1);
        end
      end
      default: begin
        if (tx_tmr_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rp_q];
            tx_tmr_d   = BIT_LOAD;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - CW'(1);
        end
      end
    endcase
    case (tx_state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // RX FSM; start is qualified at half a bit, data and stop sampled one bit apart
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_got     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_tmr_d   = HALF_LOAD;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_tmr_q == '0) begin
          if (!rxd_s2_q) begin
            rx_tmr_d   = BIT_LOAD;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_tmr_d = rx_tmr_q - CW'(1);
        end
      end
      S_DATA: begin
        if (rx_tmr_q == '0) begin
          rx_tmr_d   = BIT_LOAD;
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_tmr_d = rx_tmr_q - CW'(1);
        end
      end
      default: begin
        if (rx_tmr_q == '0) begin
          rx_got     = rxd_s2_q;
          rx_ferr_d  = rx_ferr_q | !rxd_s2_q;
          rx_state_d = S_IDLE;
        end else begin
          rx_tmr_d = rx_tmr_q - CW'(1);
        end
      end
    endcase
  end

  // Head register bypasses the memory when the new byte lands on the read slot
  always_comb begin
    rx_wp_d    = rx_wp_q + FIFO_AW'(rx_push);
    rx_rp_d    = rx_rp_q + FIFO_AW'(rx_pop);
    rx_cnt_d   = rx_cnt_q + NW'(rx_push) - NW'(rx_pop);
    rx_valid_d = (rx_cnt_d != '0);
    rx_ovf_d   = rx_ovf_q | (rx_got & rx_full);
    rx_head_d  = rx_mem[rx_rp_d];
    if (rx_push && (rx_wp_q == rx_rp_d)) rx_head_d = rx_shift_q;
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp_q] <= cpu_tx_data;
    if (rx_push) rx_mem[rx_wp_q] <= rx_shift_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b1;
      tx_ovf_q   <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      rx_head_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b0;
      rx_state_q <= S_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ready_q <= tx_ready_d;
      tx_ovf_q   <= tx_ovf_d;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_head_q  <= rx_head_d;
      rx_valid_q <= rx_valid_d;
      rx_ovf_q   <= rx_ovf_d;
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign cpu_tx_ready = tx_ready_q;
  assign cpu_rx_data  = rx_head_q;
  assign cpu_rx_valid = rx_valid_q;
  assign uart_txd     = txd_q;
  assign tx_overflow  = tx_ovf_q;
  assign rx_overflow  = rx_ovf_q;
  assign rx_frame_err = rx_ferr_q;

endmodule
